// File: rtl/march_bist_ctrl.sv
// ---------------------------------------------------------------------------
// march_bist_ctrl
//
// March C- sequencer for a single-port memory under BIST. One memory
// operation is issued per cycle while running. Read data is compared in the
// same cycle. The first failing address and element are captured, and a
// saturating mismatch count is kept.
//
// Element schedule (0 = all-zeros word, 1 = all-ones word):
//   E0 up w0 | E1 up r0,w1 | E2 up r1,w0 | E3 down r0,w1 | E4 down r1,w0 | E5 up r0
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   single-cycle pulse; begins a run from IDLE or DONE
//   mem_addr   out  memory address (AW)
//   mem_wr     out  write strobe
//   mem_rd     out  read strobe; mem_rdata is valid in the same cycle
//   mem_wdata  out  write data, all-0 or all-1 (DW)
//   mem_rdata  in   read data (DW)
//   busy       out  high while a run is in progress
//   done       out  high once a run has finished, until start or rst
//   fail       out  sticky mismatch flag for the current run
//   fail_addr  out  address of the first mismatch (AW)
//   fail_elem  out  March element (0-5) of the first mismatch
//   err_count  out  saturating count of mismatching reads (CW)
// ---------------------------------------------------------------------------
module march_bist_ctrl #(
  parameter int DW           = 4,
  parameter int AW           = 4,
  parameter int CW           = 8,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [CW-1:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [2:0]    ELEM_LAST = 3'd5;

  state_t        r_state;
  state_t        w_state_nxt;

  // r_elem/r_op/r_addr describe the operation currently on the memory pins.
  logic [2:0]    r_elem;
  logic          r_op;
  logic [AW-1:0] r_addr;
  logic          r_wr;
  logic          r_rd;
  logic [DW-1:0] r_wdata;
  logic          r_busy;
  logic          r_done;
  logic          r_fail;
  logic [AW-1:0] r_fail_addr;
  logic [2:0]    r_fail_elem;
  logic [CW-1:0] r_err_count;

  logic [2:0]    w_elem_nxt;
  logic          w_op_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic          w_wr_nxt;
  logic          w_rd_nxt;
  logic [DW-1:0] w_wdata_nxt;
  logic          w_issue;
  logic          w_start_ok;
  logic [DW-1:0] w_exp;
  logic          w_mismatch;

  // ---- element decode helpers ----
  // Op 0 of every element except E0 is a read; everything else is a write.
  function automatic logic is_read(input logic [2:0] e, input logic op);
    return (e != 3'd0) && (op == 1'b0);
  endfunction

  // E0 and E5 have a single op per address; the others have two.
  function automatic logic is_last_op(input logic [2:0] e, input logic op);
    return ((e == 3'd0) || (e == ELEM_LAST)) ? 1'b1 : op;
  endfunction

  function automatic logic is_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Expected read word: ones in E2/E4, zeros in E1/E3/E5.
  function automatic logic rd_bit(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  // Written word: ones in E1/E3, zeros in E0/E2/E4.
  function automatic logic wr_bit(input logic [2:0] e);
    return e[0];
  endfunction

  function automatic logic [AW-1:0] addr_first(input logic [2:0] e);
    return is_down(e) ? {AW{1'b1}} : {AW{1'b0}};
  endfunction

  function automatic logic [AW-1:0] addr_last(input logic [2:0] e);
    return is_down(e) ? {AW{1'b0}} : {AW{1'b1}};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // Read check is combinational on the returned data.
  assign w_exp      = {DW{rd_bit(r_elem)}};
  assign w_mismatch = r_rd && (mem_rdata != w_exp);
  assign w_start_ok = start && (r_state != S_RUN);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state and next-operation logic ----
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_op_nxt    = r_op;
    w_addr_nxt  = r_addr;
    w_wr_nxt    = 1'b0;
    w_rd_nxt    = 1'b0;
    w_wdata_nxt = '0;
    w_issue     = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_elem_nxt  = 3'd0;
          w_op_nxt    = 1'b0;
          w_addr_nxt  = '0;
          w_issue     = 1'b1;
        end
      end
      S_RUN: begin
        if ((STOP_ON_FAIL != 0) && w_mismatch) begin
          w_state_nxt = S_DONE;
        end else if (!is_last_op(r_elem, r_op)) begin
          w_op_nxt = 1'b1;
          w_issue  = 1'b1;
        end else if (r_addr != addr_last(r_elem)) begin
          // Step only while short of the end value; no wrap inside an element.
          w_op_nxt   = 1'b0;
          w_addr_nxt = is_down(r_elem) ? (r_addr - ADDR_ONE) : (r_addr + ADDR_ONE);
          w_issue    = 1'b1;
        end else if (r_elem == ELEM_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_elem_nxt = r_elem + 3'd1;
          w_op_nxt   = 1'b0;
          w_addr_nxt = addr_first(r_elem + 3'd1);
          w_issue    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_issue) begin
      w_rd_nxt    = is_read(w_elem_nxt, w_op_nxt);
      w_wr_nxt    = !is_read(w_elem_nxt, w_op_nxt);
      w_wdata_nxt = is_read(w_elem_nxt, w_op_nxt) ? {DW{1'b0}} : {DW{wr_bit(w_elem_nxt)}};
    end
  end

  // ---- registered sequencer and result state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_elem      <= '0;
      r_op        <= 1'b0;
      r_addr      <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
      r_err_count <= '0;
    end else begin
      r_elem  <= w_elem_nxt;
      r_op    <= w_op_nxt;
      r_addr  <= w_addr_nxt;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_wdata <= w_wdata_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);

      if (w_start_ok) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_elem <= '0;
        r_err_count <= '0;
      end else if (w_mismatch) begin
        r_err_count <= sat_inc(r_err_count);
        // Only the first mismatch of a run is recorded.
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_addr;
          r_fail_elem <= r_elem;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wr    = r_wr;
  assign mem_rd    = r_rd;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_elem = r_fail_elem;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_march_bist_ctrl.sv
module tb_march_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st;
  logic sel;   // 0: normal instance, 1: stop-on-fail instance

  // fault injection shared by both memory models
  logic [3:0] f_addr, f_sa0, f_sa1;

  logic       start0, start1;
  logic [3:0] addr0, wdata0, rdata0, fa0;
  logic       wr0, rd0, busy0, done0, fail0;
  logic [2:0] fe0;
  logic [7:0] err0;
  logic [3:0] addr1, wdata1, rdata1, fa1;
  logic       wr1, rd1, busy1, done1, fail1;
  logic [2:0] fe1;
  logic [7:0] err1;

  logic [3:0] mem0 [16];
  logic [3:0] mem1 [16];

  assign start0 = st & ~sel;
  assign start1 = st & sel;

  march_bist_ctrl #(.DW(4), .AW(4), .CW(8), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .rst(rst), .start(start0),
    .mem_addr(addr0), .mem_wr(wr0), .mem_rd(rd0), .mem_wdata(wdata0),
    .mem_rdata(rdata0), .busy(busy0), .done(done0), .fail(fail0),
    .fail_addr(fa0), .fail_elem(fe0), .err_count(err0));

  march_bist_ctrl #(.DW(4), .AW(4), .CW(8), .STOP_ON_FAIL(1)) dut_stop (
    .clk(clk), .rst(rst), .start(start1),
    .mem_addr(addr1), .mem_wr(wr1), .mem_rd(rd1), .mem_wdata(wdata1),
    .mem_rdata(rdata1), .busy(busy1), .done(done1), .fail(fail1),
    .fail_addr(fa1), .fail_elem(fe1), .err_count(err1));

  // memory models with stuck-at bits on one address
  always @(posedge clk) if (wr0) mem0[addr0] <= wdata0;
  always @(posedge clk) if (wr1) mem1[addr1] <= wdata1;
  assign rdata0 = (addr0 == f_addr) ? ((mem0[addr0] & ~f_sa0) | f_sa1) : mem0[addr0];
  assign rdata1 = (addr1 == f_addr) ? ((mem1[addr1] & ~f_sa0) | f_sa1) : mem1[addr1];

  // selected-instance view
  logic [3:0] s_addr, s_wd, s_fa;
  logic       s_wr, s_rd, s_busy, s_done, s_fail;
  logic [2:0] s_fe;
  logic [7:0] s_err;
  assign s_addr = sel ? addr1  : addr0;
  assign s_wd   = sel ? wdata1 : wdata0;
  assign s_wr   = sel ? wr1    : wr0;
  assign s_rd   = sel ? rd1    : rd0;
  assign s_busy = sel ? busy1  : busy0;
  assign s_done = sel ? done1  : done0;
  assign s_fail = sel ? fail1  : fail0;
  assign s_fa   = sel ? fa1    : fa0;
  assign s_fe   = sel ? fe1    : fe0;
  assign s_err  = sel ? err1   : err0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference March C- operation list
  typedef struct {
    logic [3:0] a;
    logic       wr;
    logic       rd;
    logic [3:0] wd;
  } op_t;
  op_t exp_ops[$];

  task automatic build_ops();
    // per element: number of ops, and for each op {is_read, data bit}
    int          nops [6] = '{1, 2, 2, 2, 2, 1};
    logic [1:0]  kind [6][2] = '{'{2'b00, 2'b00}, '{2'b10, 2'b01}, '{2'b11, 2'b00},
                                 '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b10, 2'b00}};
    op_t o;
    exp_ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 16; i++) begin
        for (int k = 0; k < nops[e]; k++) begin
          o.a  = ((e == 3) || (e == 4)) ? 4'(15 - i) : 4'(i);
          o.rd = kind[e][k][1];
          o.wr = ~kind[e][k][1];
          o.wd = {4{kind[e][k][0]}};
          exp_ops.push_back(o);
        end
      end
    end
  endtask

  typedef struct {
    logic       stop;
    logic [3:0] fa_in;
    logic [3:0] sa0;
    logic [3:0] sa1;
    int         cyc;
    logic       fail;
    logic [3:0] fa;
    logic [2:0] fe;
    logic [7:0] err;
  } vec_t;

  task automatic run_vec(input string tag, input vec_t v, input int extra_at);
    int cyc;
    int seq_err;
    int strobes;
    f_addr = v.fa_in; f_sa0 = v.sa0; f_sa1 = v.sa1;
    sel = v.stop;
    @(negedge clk) st = 1'b1;
    @(negedge clk) st = 1'b0;
    check({tag, " clear_on_start"}, {s_busy, s_done, s_fail, s_err}, {1'b1, 1'b0, 1'b0, 8'd0});
    cyc = 0;
    seq_err = 0;
    while (s_busy && cyc < 400) begin
      if (cyc >= exp_ops.size())
        seq_err++;
      else if (s_addr !== exp_ops[cyc].a || s_wr !== exp_ops[cyc].wr ||
               s_rd !== exp_ops[cyc].rd || (exp_ops[cyc].wr && s_wd !== exp_ops[cyc].wd))
        seq_err++;
      cyc++;
      st = (cyc == extra_at);
      @(negedge clk);
    end
    st = 1'b0;
    check({tag, " busy_cycles"}, cyc, v.cyc);
    check({tag, " op_seq_errors"}, seq_err, 0);
    check({tag, " done"}, s_done, 1'b1);
    check({tag, " fail"}, s_fail, v.fail);
    check({tag, " fail_addr"}, s_fa, v.fa);
    check({tag, " fail_elem"}, s_fe, v.fe);
    check({tag, " err_count"}, s_err, v.err);
    strobes = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_wr || s_rd || s_busy || !s_done) strobes++;
    end
    check({tag, " quiet_in_done"}, strobes, 0);
  endtask

  vec_t vecs [7];

  initial begin
    vec_t v;
    int cyc;
    // stop, fault addr, sa0, sa1, busy cycles, fail, fail_addr, fail_elem, err
    vecs[0] = '{1'b0, 4'd0,  4'h0, 4'h0, 160, 1'b0, 4'd0,  3'd0, 8'd0};
    vecs[1] = '{1'b0, 4'd5,  4'h1, 4'h0, 160, 1'b1, 4'd5,  3'd2, 8'd2};
    vecs[2] = '{1'b0, 4'd10, 4'h0, 4'h4, 160, 1'b1, 4'd10, 3'd1, 8'd3};
    vecs[3] = '{1'b0, 4'd0,  4'h0, 4'h0, 160, 1'b0, 4'd0,  3'd0, 8'd0};
    vecs[4] = '{1'b0, 4'd0,  4'h8, 4'h0, 160, 1'b1, 4'd0,  3'd2, 8'd2};
    vecs[5] = '{1'b0, 4'd15, 4'h0, 4'hF, 160, 1'b1, 4'd15, 3'd1, 8'd3};
    vecs[6] = '{1'b1, 4'd5,  4'h1, 4'h0, 59,  1'b1, 4'd5,  3'd2, 8'd1};

    build_ops();
    rst = 1'b1; st = 1'b0; sel = 1'b0;
    f_addr = 4'd0; f_sa0 = 4'd0; f_sa1 = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {addr0, wr0, rd0, wdata0, busy0, done0, fail0, fa0, fe0, err0}, 0);
    check("reset_outputs_stop", {addr1, wr1, rd1, wdata1, busy1, done1, fail1, fa1, fe1, err1}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_strobe", {wr0, rd0, busy0, done0}, 0);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), vecs[i], 0);

    // start pulsed mid-run is ignored
    run_vec("start_in_run", vecs[1], 80);

    // reset mid-run with a fault present
    sel = 1'b0;
    f_addr = 4'd10; f_sa0 = 4'h0; f_sa1 = 4'h4;
    @(negedge clk) st = 1'b1;
    @(negedge clk) st = 1'b0;
    cyc = 1;
    while (cyc < 50 && busy0) begin
      @(negedge clk);
      cyc++;
    end
    check("pre_reset_busy", busy0, 1'b1);
    check("pre_reset_fail", {fail0, err0}, {1'b1, 8'd1});
    rst = 1'b1;
    @(negedge clk);
    check("mid_run_reset", {addr0, wr0, rd0, wdata0, busy0, done0, fail0, fa0, fe0, err0}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {wr0, rd0, busy0, done0}, 0);
    run_vec("after_reset", vecs[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/march_bist_ctrl.md
Name: march_bist_ctrl

Overview:
- Self-contained March C- sequencer for the memory BIST datapath.
- Drives a single-port memory's address, write, read and write-data lines; checks read data on the same cycle; records the first failing address and element, and keeps an error count.
- Sits between the BIST start/done interface and the memory array. It replaces separate address/data generator control with one scheduled engine.

Parameters:
- DW, 4, memory data width in bits.
- AW, 4, memory address width; depth = 2^AW.
- CW, 8, width of err_count.
- STOP_ON_FAIL, 0, 1 = end the run on the first mismatch; 0 = run all elements.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a run from IDLE or DONE.
- mem_addr  out  AW  memory address.
- mem_wr  out  1  write strobe; memory writes mem_wdata at this clock edge.
- mem_rd  out  1  read strobe; memory drives mem_rdata combinationally in the same cycle.
- mem_wdata  out  DW  write data, all-0 or all-1.
- mem_rdata  in  DW  read data.
- busy  out  1  high while RUN.
- done  out  1  high in DONE, held until the next start or rst.
- fail  out  1  sticky; set on any mismatch in the current run.
- fail_addr  out  AW  address of the first mismatch.
- fail_elem  out  3  March element index (0-5) of the first mismatch.
- err_count  out  CW  number of mismatching reads; saturates at 2^CW-1.

Behaviour:
- Reset: state=IDLE. All outputs 0: mem_addr, mem_wr, mem_rd, mem_wdata, busy, done, fail, fail_addr, fail_elem, err_count.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start: clear fail, fail_addr, fail_elem, err_count and done. Set elem=0, op=0, addr=0. Enter RUN next cycle.
- RUN executes one memory operation per cycle. mem_wr and mem_rd are never both high, and both are 0 outside RUN.
- Elements (0 = all-zeros word, 1 = all-ones word; up = 0..2^AW-1, down = 2^AW-1..0):
  - E0 up: w0.
  - E1 up: r0, w1.
  - E2 up: r1, w0.
  - E3 down: r0, w1.
  - E4 down: r1, w0.
  - E5 up: r0.
- Sequencing within an element:
  - All ops of the element run at one address, then the address steps.
  - After the last op at the last address of the element's direction, elem increments.
  - mem_addr loads 0 for an up element and 2^AW-1 for a down element.
  - No wrap-around inside an element; the address counter never steps past its end value.
- Read check: in any cycle with mem_rd=1, mem_rdata != expected word is a mismatch.
  - On a mismatch, err_count increments, saturating at 2^CW-1.
  - If fail was 0, capture fail_addr=mem_addr and fail_elem=elem. All regs update at the clock edge; fail rises the next cycle.
  - Later mismatches do not overwrite fail_addr or fail_elem.
- Completion: after the final E5 read at address 2^AW-1, the next state is DONE: busy=0, done=1. Total RUN length is 10*2^AW cycles (160 for AW=4).
- STOP_ON_FAIL=1: a mismatch cycle transitions to DONE at the same edge. No further memory ops are issued.
- start while in RUN is ignored.
- rst in any state, including mid-RUN, returns everything to the reset values on the next edge. No further strobes are issued.
- Outputs are registered, except that the mismatch comparison is combinational on mem_rdata.

Test Plan:
- Fault-free memory model, DW=4, AW=4, start pulse:
  - busy is high for exactly 160 cycles.
  - Address order is 0..15 for E0-E2 and E5, and 15..0 for E3-E4.
  - Then done=1, fail=0, err_count=0.
- Data bit0 stuck-at-0 at address 5:
  - fail=1, fail_addr=5, fail_elem=2.
  - err_count=2 (failing reads: E2 r1 and E4 r1).
  - done after 160 cycles.
- Data bit2 stuck-at-1 at address 10:
  - fail_addr=10, fail_elem=1.
  - err_count=3 (failing reads: E1, E3 and E5 r0).
- STOP_ON_FAIL=1, same fault as the bit0 case:
  - done asserts the cycle after the E2 read at address 5.
  - No mem_wr or mem_rd afterwards; err_count=1.
- Assert rst at RUN cycle 50 while a fault is present:
  - Next cycle, all outputs are 0 and the state is IDLE.
  - A following start runs a full 160-cycle sequence from E0 address 0.
- start pulsed during RUN has no effect: the run still ends at cycle 160.
- start pulsed in DONE clears fail, err_count and done, and reruns the sequence.
